// File: rtl/swd_frontend_pkg.sv
// ============================================================================
// Module      : swd_frontend_pkg
// Description : Frame layout constants and line-ownership decode for the
//               SPI-to-SWD frame front end.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package swd_frontend_pkg;

    localparam int c_cnt_w      = 6;
    localparam int c_frame_bits = 48;
    localparam int c_req_last   = 9;

    typedef logic [c_cnt_w-1:0] bit_idx_t;

    // Shared by both layouts
    localparam bit_idx_t c_pad_first     = 6'd0;
    localparam bit_idx_t c_pad_last      = 6'd1;
    localparam bit_idx_t c_req_first     = 6'd2;
    localparam bit_idx_t c_req_last_idx  = 6'd9;
    localparam bit_idx_t c_trn_first     = 6'd10;
    localparam bit_idx_t c_ack_first     = 6'd11;
    localparam bit_idx_t c_ack_last      = 6'd13;

    // Read layout: target owns everything after the request
    localparam bit_idx_t c_rd_data_first = 6'd14;
    localparam bit_idx_t c_rd_data_last  = 6'd45;
    localparam bit_idx_t c_rd_parity     = 6'd46;
    localparam bit_idx_t c_rd_tail_trn   = 6'd47;

    // Write layout: a second turnaround hands the line back to the host
    localparam bit_idx_t c_wr_trn2       = 6'd14;
    localparam bit_idx_t c_wr_data_first = 6'd15;
    localparam bit_idx_t c_wr_data_last  = 6'd46;
    localparam bit_idx_t c_wr_parity     = 6'd47;

    typedef enum logic [0:0] {
        OWN_TARGET = 1'b0,
        OWN_HOST   = 1'b1
    } line_owner_e;

    // Who drives swdio during frame bit n
    function automatic line_owner_e host_owns(
        input bit_idx_t n,
        input logic     rnw,
        input bit_idx_t req_last,
        input bit_idx_t frame_bits
    );
        line_owner_e owner;
        owner = OWN_TARGET;
        if (n <= req_last) begin
            owner = OWN_HOST;
        end else if (!rnw && (n >= c_wr_data_first) && (n < frame_bits)) begin
            owner = OWN_HOST;
        end
        return owner;
    endfunction

endpackage

`default_nettype wire

// File: rtl/swd_frame_seq.sv
// ============================================================================
// Module      : swd_frame_seq
// Description : Frame bit counter (rising edge) and swdio drive enable
//               (falling edge) for one fixed-length SWD transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module swd_frame_seq
    import swd_frontend_pkg::*;
#(
    parameter int FRAME_BITS = c_frame_bits,
    parameter int REQ_LAST   = c_req_last
) (
    input  logic i_sck,
    input  logic i_rst_n,
    input  logic i_rnw,
    output logic o_drv_en
);

    localparam bit_idx_t c_frame_end = bit_idx_t'(FRAME_BITS);
    localparam bit_idx_t c_host_last = bit_idx_t'(REQ_LAST);

    bit_idx_t    r_bit_cnt;
    bit_idx_t    w_cnt_next;
    logic        r_drv_en;
    line_owner_e w_owner;

    always_comb begin
        w_cnt_next = r_bit_cnt;
        if (r_bit_cnt < c_frame_end) begin
            w_cnt_next = r_bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge i_sck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= w_cnt_next;
        end
    end

    // Direction is decided half a cycle ahead of the next sample point
    always_comb begin
        w_owner = host_owns(r_bit_cnt, i_rnw, c_host_last, c_frame_end);
    end

    always_ff @(negedge i_sck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drv_en <= 1'b1;
        end else begin
            r_drv_en <= (w_owner == OWN_HOST);
        end
    end

    assign o_drv_en = r_drv_en;

endmodule

`default_nettype wire

// File: rtl/swd_frame_frontend.sv
// ============================================================================
// Module      : swd_frame_frontend
// Description : SPI-to-SWD line adapter: swclk follows sck, swdio direction
//               follows the frame layout, miso returns the line to the host.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module swd_frame_frontend
    import swd_frontend_pkg::*;
#(
    parameter int FRAME_BITS = c_frame_bits,
    parameter int REQ_LAST   = c_req_last
) (
    input  logic sck,
    input  logic rst_n,
    input  logic mosi,
    output logic miso,
    input  logic rnw,
    output logic swclk,
    inout  wire  swdio
);

    logic w_drv_en;

    swd_frame_seq #(
        .FRAME_BITS (FRAME_BITS),
        .REQ_LAST   (REQ_LAST)
    ) u_seq (
        .i_sck    (sck),
        .i_rst_n  (rst_n),
        .i_rnw    (rnw),
        .o_drv_en (w_drv_en)
    );

    assign swclk = sck;
    assign swdio = w_drv_en ? mosi : 1'bz;
    // Target data reaches the host on the same edge the target is sampled
    assign miso  = w_drv_en ? mosi : swdio;

endmodule

`default_nettype wire

// File: tb/tb_swd_frame_frontend.sv
// ============================================================================
// Module      : tb_swd_frame_frontend
// Description : Directed self-checking bench for swd_frame_frontend.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_swd_frame_frontend;

    logic sck     = 1'b0;
    logic rst_n   = 1'b0;
    logic mosi    = 1'b0;
    logic rnw     = 1'b0;
    logic tgt_en  = 1'b0;
    logic tgt_val = 1'b0;
    wire  miso;
    wire  swclk;
    wire  swdio;

    int n_checks = 0;
    int n_pass   = 0;

    // Target model: drives the line only in slots it owns
    assign swdio = tgt_en ? tgt_val : 1'bz;

    swd_frame_frontend #(
        .FRAME_BITS (48),
        .REQ_LAST   (9)
    ) dut (
        .sck   (sck),
        .rst_n (rst_n),
        .mosi  (mosi),
        .miso  (miso),
        .rnw   (rnw),
        .swclk (swclk),
        .swdio (swdio)
    );

    always #10 sck = ~sck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit slot: drive just after the falling edge, leave 4 ns to settle
    task automatic slot(input logic m, input logic te, input logic tv);
        @(negedge sck);
        #1;
        mosi    = m;
        tgt_en  = te;
        tgt_val = tv;
        #4;
    endtask

    task automatic host_bit(input int k, input logic m);
        slot(m, 1'b0, 1'b0);
        check($sformatf("host swdio b%0d", k), swdio, m);
        check($sformatf("host miso b%0d", k), miso, m);
        check($sformatf("swclk low b%0d", k), swclk, 1'b0);
    endtask

    // Target-owned slot; mosi is the inverse so a wrongly driving DUT shows up
    task automatic tgt_bit(input int k, input logic v);
        slot(~v, 1'b1, v);
        check($sformatf("tgt swdio b%0d", k), swdio, v);
        check($sformatf("tgt miso b%0d", k), miso, v);
    endtask

    task automatic pulse_reset();
        @(negedge sck);
        #1;
        tgt_en = 1'b0;
        rst_n  = 1'b0;
        mosi   = 1'b1;
        #1;
        check("rst swdio hi", swdio, 1'b1);
        check("rst miso hi", miso, 1'b1);
        mosi = 1'b0;
        #1;
        check("rst swdio lo", swdio, 1'b0);
        check("rst bit_cnt", dut.u_seq.r_bit_cnt, 6'd0);
    endtask

    task automatic arm(input logic r);
        @(posedge sck);
        #2;
        rnw   = r;
        mosi  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic read_frame(input logic [7:0] req, input logic [2:0] ack,
                              input logic [31:0] data, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (k < 2)        host_bit(k, 1'b0);
            else if (k <= 9)  host_bit(k, req[k-2]);
            else if (k == 10) tgt_bit(k, 1'b0);
            else if (k <= 13) tgt_bit(k, ack[k-11]);
            else if (k <= 45) tgt_bit(k, data[k-14]);
            else if (k == 46) tgt_bit(k, ^data);
            else              tgt_bit(k, 1'b0);
        end
    endtask

    task automatic write_frame(input logic [7:0] req, input logic [2:0] ack,
                               input logic [31:0] data);
        for (int k = 0; k < 48; k++) begin
            if (k < 2)        host_bit(k, 1'b0);
            else if (k <= 9)  host_bit(k, req[k-2]);
            else if (k == 10) tgt_bit(k, 1'b0);
            else if (k <= 13) tgt_bit(k, ack[k-11]);
            else if (k == 14) tgt_bit(k, 1'b0);
            else if (k <= 46) host_bit(k, data[k-15]);
            else              host_bit(k, ^data);
        end
    endtask

    initial begin
        logic [15:0] raw;
        raw = 16'hA5C3;

        repeat (2) @(negedge sck);
        #2;
        check("reset bit_cnt", dut.u_seq.r_bit_cnt, 6'd0);
        check("reset swdio", swdio, 1'b0);

        // Raw pass-through while held in reset
        for (int i = 0; i < 16; i++) begin
            host_bit(i, raw[i]);
            @(posedge sck);
            #1;
            check($sformatf("raw swclk hi %0d", i), swclk, 1'b1);
            check($sformatf("raw swdio rise %0d", i), swdio, raw[i]);
            check($sformatf("raw bit_cnt %0d", i), dut.u_seq.r_bit_cnt, 6'd0);
        end

        // Read frame, then the line stays released
        arm(1'b1);
        read_frame(8'hA5, 3'b001, 32'h1234_5678, 48);
        tgt_bit(48, 1'b0);
        check("rd end bit_cnt", dut.u_seq.r_bit_cnt, 6'd48);

        // Write frame
        pulse_reset();
        arm(1'b0);
        write_frame(8'h81, 3'b001, 32'hDEAD_BEEF);
        tgt_bit(48, 1'b0);
        check("wr end bit_cnt", dut.u_seq.r_bit_cnt, 6'd48);

        // Reset in the middle of a read frame, then a fresh frame
        pulse_reset();
        arm(1'b1);
        read_frame(8'hA5, 3'b001, 32'h1234_5678, 20);
        pulse_reset();
        arm(1'b1);
        read_frame(8'hA5, 3'b001, 32'hCAFE_F00D, 48);

        // Saturation after the last frame bit
        for (int i = 0; i < 11; i++) begin
            tgt_bit(48 + i, 1'b0);
            check($sformatf("sat bit_cnt %0d", i), dut.u_seq.r_bit_cnt, 6'd48);
        end
        pulse_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
